// File: rtl/shift_normalizer_16bit_if.sv
// Operand/result handshake bundle for the 16-bit shift normalizer.
// The master side presents operands and consumes results; the slave side is the normalizer.
interface shift_normalizer_16bit_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        in_signed;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_data;
   logic [3:0]  out_shamt;
   logic        out_zero;

   modport master (
      output in_valid, in_data, in_signed, out_ready,
      input  in_ready, out_valid, out_data, out_shamt, out_zero
   );

   modport slave (
      input  in_valid, in_data, in_signed, out_ready,
      output in_ready, out_valid, out_data, out_shamt, out_zero
   );
endinterface

// File: rtl/shift_normalizer_16bit.sv
// Multi-cycle normalizer: left-shifts an operand one bit per cycle until it is
// normalized (unsigned: MSB set; signed: bit15 != bit14) and reports the value
// and shift count. Degenerate operands (all zero / all sign) flag out_zero.
module shift_normalizer_16bit #(
   parameter int unsigned WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   shift_normalizer_16bit_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] shreg;
   logic             sgn;
   logic [3:0]       cnt;
   logic [WIDTH-1:0] res_data;
   logic [3:0]       res_shamt;
   logic             res_zero;
   logic             is_zero;
   logic             is_norm;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and per-cycle normalization tests on the working register.
   always_comb begin
      is_zero  = 1'b0;
      is_norm  = 1'b0;
      state_nx = state;
      if (sgn) begin
         is_zero = (shreg == '0) || (shreg == '1);
         is_norm = shreg[WIDTH-1] != shreg[WIDTH-2];
      end else begin
         is_zero = (shreg == '0);
         is_norm = shreg[WIDTH-1];
      end
      case (state)
         IDLE:    if (bus.in_valid) state_nx = SHIFT;
         SHIFT:   if (is_zero || is_norm) state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Datapath: capture on accept, shift until normalized, latch result once.
   // A degenerate operand is only detectable on the first SHIFT cycle, so the
   // working register still equals the original operand when it is latched.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg     <= '0;
         sgn       <= 1'b0;
         cnt       <= '0;
         res_data  <= '0;
         res_shamt <= '0;
         res_zero  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  shreg <= bus.in_data;
                  sgn   <= bus.in_signed;
                  cnt   <= '0;
               end
            end
            SHIFT: begin
               if (is_zero) begin
                  res_data  <= shreg;
                  res_shamt <= '0;
                  res_zero  <= 1'b1;
               end else if (is_norm) begin
                  res_data  <= shreg;
                  res_shamt <= cnt;
                  res_zero  <= 1'b0;
               end else begin
                  shreg <= {shreg[WIDTH-2:0], 1'b0};
                  cnt   <= cnt + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.out_data  = res_data;
   assign bus.out_shamt = res_shamt;
   assign bus.out_zero  = res_zero;

endmodule

// File: tb/tb_shift_normalizer_16bit.sv
// Directed and randomized checks for shift_normalizer_16bit.
module tb_shift_normalizer_16bit;

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   shift_normalizer_16bit_if bus();

   shift_normalizer_16bit #(.WIDTH(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Present one operand at the current (post-edge) time, return edges until out_valid.
   // After acceptance the inputs are scrambled so the DUT must rely on its captured copy.
   task automatic run_op(input logic [15:0] d, input logic s, output int lat);
      bus.in_data   = d;
      bus.in_signed = s;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid  = 1'b0;
      bus.in_data   = ~d;
      bus.in_signed = ~s;
      lat = 0;
      while (!bus.out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b1;
      bus.in_data   = 16'h1234;
      bus.in_signed = 1'b0;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      total++; if (bus.out_data !== 16'h0000) begin bad++; $display("FAIL reset_out_data got=%h exp=0000", bus.out_data); end
      total++; if (bus.out_shamt !== 4'd0) begin bad++; $display("FAIL reset_out_shamt got=%0d exp=0", bus.out_shamt); end
      total++; if (bus.out_zero !== 1'b0) begin bad++; $display("FAIL reset_out_zero got=%b exp=0", bus.out_zero); end
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_release_valid got=%b exp=0", bus.out_valid); end
   endtask

   task automatic test_unsigned();
      logic [15:0] din [2] = '{16'h0001, 16'h8000};
      logic [15:0] dexp[2] = '{16'h8000, 16'h8000};
      logic [3:0]  sexp[2] = '{4'd15, 4'd0};
      int          lat;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         run_op(din[i], 1'b0, lat);
         total++; if (lat !== 32'(sexp[i]) + 1) begin bad++; $display("FAIL uns_latency[%0d] got=%0d exp=%0d", i, lat, sexp[i] + 1); end
         total++; if (bus.out_data !== dexp[i]) begin bad++; $display("FAIL uns_data[%0d] got=%h exp=%h", i, bus.out_data, dexp[i]); end
         total++; if (bus.out_shamt !== sexp[i]) begin bad++; $display("FAIL uns_shamt[%0d] got=%0d exp=%0d", i, bus.out_shamt, sexp[i]); end
         total++; if (bus.out_zero !== 1'b0) begin bad++; $display("FAIL uns_zero[%0d] got=%b exp=0", i, bus.out_zero); end
         @(posedge clk); #1;
         total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL uns_return_idle[%0d] got=%b exp=1", i, bus.in_ready); end
      end
   endtask

   task automatic test_signed();
      logic [15:0] din [3] = '{16'hFFFE, 16'h0001, 16'h3000};
      logic [15:0] dexp[3] = '{16'h8000, 16'h4000, 16'h6000};
      logic [3:0]  sexp[3] = '{4'd14, 4'd14, 4'd1};
      int          lat;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         run_op(din[i], 1'b1, lat);
         total++; if (lat !== 32'(sexp[i]) + 1) begin bad++; $display("FAIL sgn_latency[%0d] got=%0d exp=%0d", i, lat, sexp[i] + 1); end
         total++; if (bus.out_data !== dexp[i]) begin bad++; $display("FAIL sgn_data[%0d] got=%h exp=%h", i, bus.out_data, dexp[i]); end
         total++; if (bus.out_shamt !== sexp[i]) begin bad++; $display("FAIL sgn_shamt[%0d] got=%0d exp=%0d", i, bus.out_shamt, sexp[i]); end
         total++; if (bus.out_zero !== 1'b0) begin bad++; $display("FAIL sgn_zero[%0d] got=%b exp=0", i, bus.out_zero); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_zero();
      logic [15:0] din[3] = '{16'h0000, 16'hFFFF, 16'h0000};
      logic        sin[3] = '{1'b0, 1'b1, 1'b1};
      int          lat;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         run_op(din[i], sin[i], lat);
         total++; if (lat !== 1) begin bad++; $display("FAIL zero_latency[%0d] got=%0d exp=1", i, lat); end
         total++; if (bus.out_zero !== 1'b1) begin bad++; $display("FAIL zero_flag[%0d] got=%b exp=1", i, bus.out_zero); end
         total++; if (bus.out_shamt !== 4'd0) begin bad++; $display("FAIL zero_shamt[%0d] got=%0d exp=0", i, bus.out_shamt); end
         total++; if (bus.out_data !== din[i]) begin bad++; $display("FAIL zero_data[%0d] got=%h exp=%h", i, bus.out_data, din[i]); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      int lat;
      bus.out_ready = 1'b0;
      run_op(16'h00F0, 1'b0, lat);
      total++; if (lat !== 9) begin bad++; $display("FAIL bp_latency got=%0d exp=9", lat); end
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 16'h1234;
            bus.in_signed = 1'b0;
         end else begin
            bus.in_valid = 1'b0;
         end
         total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", c, bus.out_valid); end
         total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", c, bus.in_ready); end
         total++; if (bus.out_data !== 16'hF000) begin bad++; $display("FAIL bp_data[%0d] got=%h exp=F000", c, bus.out_data); end
         total++; if (bus.out_shamt !== 4'd8) begin bad++; $display("FAIL bp_shamt[%0d] got=%0d exp=8", c, bus.out_shamt); end
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid got=%b exp=0", bus.out_valid); end
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready got=%b exp=1", bus.in_ready); end
      @(posedge clk); #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_not_queued got=%b exp=1", bus.in_ready); end
      total++; if (bus.out_data !== 16'hF000) begin bad++; $display("FAIL bp_retain_data got=%h exp=F000", bus.out_data); end
   endtask

   task automatic test_reset_mid();
      int lat;
      bus.out_ready = 1'b1;
      bus.in_data   = 16'h0001;
      bus.in_signed = 1'b0;
      bus.in_valid  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", bus.out_valid); end
      total++; if (bus.out_data !== 16'h0000) begin bad++; $display("FAIL rmid_data got=%h exp=0000", bus.out_data); end
      total++; if (bus.out_shamt !== 4'd0) begin bad++; $display("FAIL rmid_shamt got=%0d exp=0", bus.out_shamt); end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b exp=1", bus.in_ready); end
      run_op(16'h0100, 1'b0, lat);
      total++; if (lat !== 8) begin bad++; $display("FAIL rmid_next_latency got=%0d exp=8", lat); end
      total++; if (bus.out_shamt !== 4'd7) begin bad++; $display("FAIL rmid_next_shamt got=%0d exp=7", bus.out_shamt); end
      total++; if (bus.out_data !== 16'h8000) begin bad++; $display("FAIL rmid_next_data got=%h exp=8000", bus.out_data); end
      // Reset while holding a result in DONE must drop out_valid without a clock edge.
      bus.out_ready = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rdone_valid got=%b exp=0", bus.out_valid); end
      total++; if (bus.out_zero !== 1'b0 || bus.out_data !== 16'h0000) begin bad++; $display("FAIL rdone_outputs got=%h/%b exp=0000/0", bus.out_data, bus.out_zero); end
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [15:0] d;
      logic        s;
      logic        ezero;
      int          esh;
      int          lat;
      int          k;
      logic        found;
      for (int n = 0; n < 1000; n++) begin
         d = 16'($urandom) >> $urandom_range(0, 15);
         if ($urandom_range(0, 1) == 1) d = ~d;
         s = 1'($urandom_range(0, 1));
         ezero = s ? (d == 16'h0000 || d == 16'hFFFF) : (d == 16'h0000);
         esh   = 0;
         found = 1'b0;
         if (!ezero) begin
            if (!s) begin
               for (int i = 15; i >= 0; i--)
                  if (!found && d[i]) begin esh = 15 - i; found = 1'b1; end
            end else begin
               for (int i = 14; i >= 0; i--)
                  if (!found && d[i] != d[15]) begin esh = 14 - i; found = 1'b1; end
            end
         end
         bus.out_ready = 1'b0;
         run_op(d, s, lat);
         total++; if (lat !== esh + 1) begin bad++; $display("FAIL rnd_latency d=%h s=%b got=%0d exp=%0d", d, s, lat, esh + 1); end
         total++; if (bus.out_zero !== ezero) begin bad++; $display("FAIL rnd_zero d=%h s=%b got=%b exp=%b", d, s, bus.out_zero, ezero); end
         total++; if (bus.out_shamt !== 4'(esh)) begin bad++; $display("FAIL rnd_shamt d=%h s=%b got=%0d exp=%0d", d, s, bus.out_shamt, esh); end
         total++; if (bus.out_data !== 16'(d << esh)) begin bad++; $display("FAIL rnd_data d=%h s=%b got=%h exp=%h", d, s, bus.out_data, 16'(d << esh)); end
         k = 0;
         do begin
            bus.out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            k++;
         end while (bus.out_valid && k < 50);
         bus.out_ready = 1'b0;
         total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rnd_handshake d=%h got=%b exp=0", d, bus.out_valid); end
      end
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_data   = 16'h0000;
      bus.in_signed = 1'b0;
      bus.out_ready = 1'b0;
      rst_n         = 1'b1;
      #2;
      test_reset();
      test_unsigned();
      test_signed();
      test_zero();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_normalizer_16bit.md
Name: shift_normalizer_16bit

Overview:
Multi-cycle normalizer that performs the inverse of the datapath barrel shifter's SLL. It takes a 16-bit operand, left-shifts it one bit per cycle until it is normalized, and returns the normalized value and the shift amount that was applied. Normalization is either unsigned (MSB set) or signed (bit15 differs from bit14). It sits beside the ALU shifter, with a valid/ready handshake on both sides, for count-leading-zero / leading-sign style operations.

Parameters:
WIDTH, 16, operand width; only 16 is supported; the shift amount is fixed at 4 bits.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand present on in_data/in_signed.
in_ready  output  1  block can accept an operand (high only in IDLE).
in_data  input  16  operand to normalize.
in_signed  input  1  0 = unsigned normalization, 1 = signed normalization.
out_valid  output  1  result present on out_data/out_shamt/out_zero.
out_ready  input  1  consumer accepts the result.
out_data  output  16  normalized value, equal to in_data SLL out_shamt.
out_shamt  output  4  number of left shifts applied.
out_zero  output  1  operand had no normalizable bit (all zero, or all sign bits).

Behaviour:
- Reset:
  - Clock is clk; reset is rst_n, asynchronous, active-low.
  - While rst_n is low: state = IDLE; out_valid = 0; out_data = 0x0000; out_shamt = 0; out_zero = 0; internal shift register and counter = 0.
  - Inputs are ignored while rst_n is low.
- States: IDLE, SHIFT, DONE. in_ready = (state == IDLE); out_valid = (state == DONE).
- IDLE:
  - On in_valid && in_ready at a rising edge: capture in_data into the shift register, capture in_signed, clear the counter, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, evaluated each cycle on the current register value (reg):
  - Zero condition. Unsigned: reg == 0x0000. Signed: reg == 0x0000 or reg == 0xFFFF. This can only hold on the first SHIFT cycle, because shifting stops before a non-degenerate value degenerates.
    - If true: out_zero = 1, out_shamt = 0, out_data = original operand, go to DONE.
  - Normalized condition. Unsigned: reg[15] == 1. Signed: reg[15] != reg[14].
    - If true: out_data = reg, out_shamt = count, out_zero = 0, go to DONE.
  - Else: reg <= {reg[14:0], 0}, count <= count + 1, stay in SHIFT.
- Shift bounds: the counter never exceeds 15 (unsigned) or 14 (signed).
  - Unsigned input 0x0001 gives shamt 15.
  - Signed inputs 0x0001 and 0xFFFE give shamt 14.
  - No wrap-around of the counter is possible.
- Latency: out_valid rises at the (out_shamt + 1)th rising edge after the accept edge. Zero inputs take 1 edge.
- DONE:
  - out_valid = 1.
  - out_data, out_shamt and out_zero are held stable until the handshake.
  - On out_valid && out_ready at a rising edge: go to IDLE. in_ready is high the following cycle.
  - No new operand is accepted in DONE, so there is no same-cycle accept/complete overlap.
- Backpressure: any number of cycles with out_ready low leaves all outputs unchanged. in_valid pulses during SHIFT or DONE are ignored, not queued.
- Output registers: out_data, out_shamt and out_zero are updated only on the SHIFT→DONE transition. Between operations they retain the last result.
- Reset mid-operation: asserting rst_n in SHIFT or DONE immediately aborts. out_valid drops asynchronously and all outputs clear. The operation is lost and the next accepted operand starts cleanly.
- Invariant: in every non-zero case, out_data == in_data << out_shamt (16-bit truncation). In the unsigned case, out_data[15] == 1.

Test Plan:
1. Unsigned edge cases.
   - in_signed=0, in_data=0x0001, out_ready=1 → out_data=0x8000, out_shamt=15, out_zero=0; out_valid 16 edges after accept.
   - in_data=0x8000 → out_shamt=0, out_data=0x8000; out_valid 1 edge after accept.
2. Signed cases.
   - in_signed=1, in_data=0xFFFE → out_data=0x8000, out_shamt=14.
   - in_data=0x0001 → out_data=0x4000, out_shamt=14.
   - in_data=0x3000 → out_data=0x6000, out_shamt=1.
3. Zero/degenerate cases.
   - Unsigned 0x0000 → out_zero=1, out_shamt=0, out_data=0x0000; 1-edge latency.
   - Signed 0xFFFF → out_zero=1, out_data=0xFFFF.
   - Signed 0x0000 → out_zero=1, out_data=0x0000.
4. Backpressure: unsigned 0x00F0 with out_ready held low for 5 cycles after out_valid → out_data=0xF000 and out_shamt=8 held stable, in_ready=0. An in_valid pulse with 0x1234 during the stall is ignored. Release out_ready → IDLE next cycle, in_ready=1.
5. Reset mid-operation: start unsigned 0x0001, pull rst_n low after 5 cycles in SHIFT → out_valid=0 and outputs=0 immediately, in_ready=1 after release. Then issue unsigned 0x0100 → out_shamt=7, out_data=0x8000.
6. Randomized sweep (≥1000 operands, both modes, random out_ready) → for every non-zero result, out_data == in_data<<out_shamt, the mode's normalized condition holds, and latency == out_shamt+1 edges.
